// File: rtl/mux_4to1_if.sv
// Select/data bundle for the 4:1 leaf selector, for benches and wrappers
// that want one handle on the s0/s1/i0..i3/y group.
interface mux_4to1_if #(
  parameter int WIDTH = 1
);
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [WIDTH-1:0] y;

  modport master (
    output s0, s1, i0, i1, i2, i3,
    input  y
  );

  modport slave (
    input  s0, s1, i0, i1, i2, i3,
    output y
  );
endinterface

// File: rtl/mux_4to1.sv
// WIDTH-bit 4:1 selector built as a two-level cascade of 2:1 stages.
// Define MUX_4TO1_REG_OUT_EN to register y (async active-low reset to zero).
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst_n
);

  // The conditional operator merges both arms bitwise on an unknown select,
  // so agreeing bits pass through and differing bits go X.
  function automatic logic [WIDTH-1:0] mux2(
    input logic             sel,
    input logic [WIDTH-1:0] in0,
    input logic [WIDTH-1:0] in1
  );
    return sel ? in1 : in0;
  endfunction

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] sel_p0;

  assign a_p0   = mux2(s0, i0, i1);
  assign b_p0   = mux2(s0, i2, i3);
  assign sel_p0 = mux2(s1, a_p0, b_p0);

  // ---- p0 -> p1: optional output register ----
`ifdef MUX_4TO1_REG_OUT_EN
  logic [WIDTH-1:0] y_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_p1 <= '0;
    else        y_p1 <= sel_p0;
  end

  assign y = y_p1;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
  assign y = sel_p0;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: 8-bit selector plus a 1-bit 8:1 composition.
// Adapts its expected latency to whether MUX_4TO1_REG_OUT_EN is defined.
module tb_mux_4to1;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  logic rst_n = 1'b0;

  always #5 if (clk_en) clk = ~clk;

  mux_4to1_if #(.WIDTH(8)) bus ();

  mux_4to1 #(.WIDTH(8)) u_dut (
    .s0(bus.s0), .s1(bus.s1),
    .i0(bus.i0), .i1(bus.i1), .i2(bus.i2), .i3(bus.i3),
    .y(bus.y), .clk(clk), .rst_n(rst_n)
  );

  logic [2:0] s8;
  logic [7:0] d8;
  logic       y_lo, y_hi, y8, s2_q;

  mux_4to1 #(.WIDTH(1)) u_lo (
    .s0(s8[0]), .s1(s8[1]), .i0(d8[0]), .i1(d8[1]), .i2(d8[2]), .i3(d8[3]),
    .y(y_lo), .clk(clk), .rst_n(rst_n)
  );
  mux_4to1 #(.WIDTH(1)) u_hi (
    .s0(s8[0]), .s1(s8[1]), .i0(d8[4]), .i1(d8[5]), .i2(d8[6]), .i3(d8[7]),
    .y(y_hi), .clk(clk), .rst_n(rst_n)
  );

`ifdef MUX_4TO1_REG_OUT_EN
  // The s2 stage must see the select aligned with the registered leaf outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_q <= 1'b0;
    else        s2_q <= s8[2];
  end
`else
  assign s2_q = s8[2];
`endif
  assign y8 = s2_q ? y_hi : y_lo;

  typedef struct {
    string      name;
    logic [7:0] e4;
    logic       e8;
    logic       elo;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: y=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: selection is plain array indexing by the select value.
  task automatic apply(input string name, input logic [1:0] sel, input bit force_e,
                       input logic [7:0] forced, input logic [7:0] d [4],
                       input logic [2:0] sel8, input logic [7:0] bits8);
    bus.s0 = sel[0];
    bus.s1 = sel[1];
    bus.i0 = d[0];
    bus.i1 = d[1];
    bus.i2 = d[2];
    bus.i3 = d[3];
    s8 = sel8;
    d8 = bits8;
    cur.name = name;
    cur.e4   = force_e ? forced : d[sel];
    cur.e8   = bits8[sel8];
    cur.elo  = bits8[{1'b0, sel8[1:0]}];
    have_cur = 1'b1;
  endtask

  task automatic step(input string name, input logic [1:0] sel, input bit force_e,
                      input logic [7:0] forced, input logic [7:0] d [4],
                      input logic [2:0] sel8, input logic [7:0] bits8);
`ifdef MUX_4TO1_REG_OUT_EN
    @(posedge clk);
    if (have_cur) q.push_back(cur);
    #2 apply(name, sel, force_e, forced, d, sel8, bits8);
`else
    @(posedge clk);
    #2 apply(name, sel, force_e, forced, d, sel8, bits8);
    q.push_back(cur);
`endif
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check8({e.name, "_y4"}, bus.y, e.e4);
      check8({e.name, "_y8"}, {7'd0, y8}, {7'd0, e.e8});
      check8({e.name, "_ylo"}, {7'd0, y_lo}, {7'd0, e.elo});
    end
  end

  initial begin
    logic [7:0] dd [4];
    logic [1:0] sel;
    dd[0] = 8'h11; dd[1] = 8'h22; dd[2] = 8'h44; dd[3] = 8'h88;
    bus.s0 = 1'b0; bus.s1 = 1'b0;
    bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
    s8 = 3'd0; d8 = 8'd0;

`ifdef MUX_4TO1_REG_OUT_EN
    // Reset held with no clock, then release and step through edges.
    bus.s1 = 1'b1; bus.s0 = 1'b0; bus.i2 = 8'hA5;
    #20 check8("rst_hold", bus.y, 8'h00);
    rst_n = 1'b1;
    #3 check8("pre_edge", bus.y, 8'h00);
    clk_en = 1'b1;
    @(posedge clk); #1 check8("first_edge", bus.y, 8'hA5);
    #1 bus.s0 = 1'b1; bus.i3 = 8'h3C;
    #1 check8("hold_between", bus.y, 8'hA5);
    @(posedge clk); #1 check8("sel11_edge", bus.y, 8'h3C);
    #2 rst_n = 1'b0;
    #1 check8("async_rst", bus.y, 8'h00);
    #1 rst_n = 1'b1;
    #1 check8("rel_no_edge", bus.y, 8'h00);
    @(posedge clk); #1 check8("reload", bus.y, 8'h3C);
`else
    rst_n = 1'b1;
    bus.s1 = 1'b1; bus.s0 = 1'b0; bus.i2 = 8'hA5;
    #1 check8("comb_now", bus.y, 8'hA5);
    bus.s0 = 1'b1; bus.i3 = 8'h3C;
    #1 check8("comb_follow", bus.y, 8'h3C);
    clk_en = 1'b1;
`endif

    // Directed sweep: 8-bit one-hot-ish data, 8:1 pattern 0,1,1,0,1,1,0,1.
    for (int k = 0; k < 8; k++) begin
      sel = k[1:0];
      step($sformatf("dir%0d", k), sel, 1'b0, 8'h00, dd, k[2:0], 8'hB6);
    end

    // Unknown high select with agreeing candidates i0/i2.
    dd[0] = 8'hFF; dd[2] = 8'hFF;
    step("xsel", 2'b00, 1'b1, 8'hFF, dd, 3'd0, 8'hB6);
    bus.s1 = 1'bx;

    for (int k = 0; k < 150; k++) begin
      for (int j = 0; j < 4; j++) dd[j] = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      step($sformatf("rnd%0d", k), sel, 1'b0, 8'h00, dd,
           3'($urandom_range(0, 7)), 8'($urandom));
    end

`ifdef MUX_4TO1_REG_OUT_EN
    @(posedge clk);
    q.push_back(cur);
`endif

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
